instr_fetch_mem: RTL and testbench
==================================

INSTR_FETCH_MEM -- requirements
Module: instr_fetch_mem

Interface
REQ-001 SHALL have parameter INS_ADDRESS, default 9: byte-address width; depth = 2**(INS_ADDRESS-2) words.
REQ-002 SHALL have parameter DATA_W, default 32: instruction word width.
REQ-003 SHALL have parameter NOP_WORD, default 32'h00000013 (addi x0,x0,0): bubble/fill word.
REQ-004 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1: reset, synchronous and active-low.
REQ-006 SHALL have port load_en  input  1: program-load write strobe.
REQ-007 SHALL have port load_addr  input  INS_ADDRESS: load byte address; bits [1:0] ignored.
REQ-008 SHALL have port load_data  input  DATA_W: word to write.
REQ-009 SHALL have port req_valid  input  1: fetch request present.
REQ-010 SHALL have port req_addr  input  INS_ADDRESS: fetch byte address (PC).
REQ-011 SHALL have port req_ready  output  1: request accepted this cycle when req_valid=1.
REQ-012 SHALL have port stall  input  1: downstream hold; response must not advance.
REQ-013 SHALL have port flush  input  1: discard the pending response and any same-cycle request.
REQ-014 SHALL have port rsp_valid  output  1: response registers hold a live instruction.
REQ-015 SHALL have port rsp_data  output  DATA_W: fetched instruction.
REQ-016 SHALL have port rsp_addr  output  INS_ADDRESS: byte address of rsp_data.
REQ-017 SHALL have port rsp_misaligned  output  1: response came from a request with req_addr[1:0] != 0.

Function
REQ-018 SHALL index the word array with addr[INS_ADDRESS-1:2] for both load and fetch.
REQ-019 SHALL drive req_ready = rst_n & ~stall & ~flush & ~load_en (combinational).
REQ-020 SHALL write mem[load_addr index] <= load_data on the edge where load_en=1; fetch is blocked in that cycle, so there is no read/write collision.
REQ-021 SHALL accept a fetch when req_valid & req_ready, with one-cycle latency: next edge rsp_valid=1, rsp_addr=req_addr, rsp_data=mem[index].
REQ-022 SHALL, for a misaligned accepted request, return rsp_data=NOP_WORD, rsp_misaligned=1, rsp_valid=1, rsp_addr=req_addr.
REQ-023 SHALL hold rsp_valid, rsp_data, rsp_addr and rsp_misaligned bit-stable on every edge with stall=1 and flush=0, and shall not read memory in that cycle.
REQ-024 SHALL, on an edge with flush=1, set rsp_valid=0, rsp_data=NOP_WORD and rsp_misaligned=0; flush overrides stall and load_en is still honoured.
REQ-025 SHALL, on an edge with no accepted request and stall=0 and flush=0, set rsp_valid=0 and rsp_data=NOP_WORD (bubble).
REQ-026 SHALL, for back-to-back accepted requests, produce one response per cycle in request order at full throughput.
REQ-027 SHALL wrap addresses naturally: no out-of-range condition, because index width equals array depth.
REQ-028 SHALL initialise every memory word to NOP_WORD at time zero (simulation and FPGA init).

Reset
REQ-029 SHALL, on an edge with rst_n=0, set rsp_valid=0, rsp_data=NOP_WORD, rsp_addr=0 and rsp_misaligned=0; reset overrides flush, stall and requests.
REQ-030 SHALL preserve memory contents across reset; load_en is ignored while rst_n=0.
REQ-031 SHALL hold req_ready=0 while rst_n=0; reset asserted mid-stall discards the held response.

Verification
REQ-032 SHALL cover load then fetch: load 0x00800093 at addr 0x004, then fetch 0x004 -> next cycle rsp_valid=1, rsp_data=0x00800093, rsp_addr=0x004.
REQ-033 SHALL cover streaming: fetch 0x000, 0x004 and 0x008 on consecutive cycles -> three consecutive responses in order, no bubbles.
REQ-034 SHALL cover stall hold: stall=1 for 3 cycles after a response -> outputs unchanged for all 3 cycles, req_ready=0; stall release resumes the stream.
REQ-035 SHALL cover flush with stall: flush=1 with stall=1 and req_valid=1 -> next cycle rsp_valid=0, rsp_data=0x00000013, request not accepted.
REQ-036 SHALL cover misaligned fetch: fetch 0x006 -> rsp_misaligned=1, rsp_data=0x00000013, rsp_addr=0x006.
REQ-037 SHALL cover reset: rst_n=0 for 1 cycle during a held response -> rsp_valid=0, rsp_addr=0; a later fetch of 0x004 still returns 0x00800093.

Source files
------------

// File: rtl/instr_fetch_mem.sv
// Instruction memory with a one-cycle registered fetch port.
// Program load port, stall hold, flush bubble and misalignment flag.
module instr_fetch_mem #(
    parameter int                INS_ADDRESS = 9,
    parameter int                DATA_W      = 32,
    parameter logic [DATA_W-1:0] NOP_WORD    = 32'h00000013
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load_en,
    input  logic [INS_ADDRESS-1:0] load_addr,
    input  logic [DATA_W-1:0]      load_data,
    input  logic                   req_valid,
    input  logic [INS_ADDRESS-1:0] req_addr,
    output logic                   req_ready,
    input  logic                   stall,
    input  logic                   flush,
    output logic                   rsp_valid,
    output logic [DATA_W-1:0]      rsp_data,
    output logic [INS_ADDRESS-1:0] rsp_addr,
    output logic                   rsp_misaligned
);

    localparam int IDX_W = INS_ADDRESS - 2;
    localparam int DEPTH = 2 ** IDX_W;

    // Word array; every slot starts out as a harmless NOP.
    logic [DATA_W-1:0] mem [DEPTH] = '{default: NOP_WORD};

    logic [IDX_W-1:0] load_idx;
    logic [IDX_W-1:0] req_idx;
    logic             req_misaligned;
    logic             accept;
    logic             unused_load_lsb;

    assign load_idx        = load_addr[INS_ADDRESS-1:2];
    assign req_idx         = req_addr[INS_ADDRESS-1:2];
    assign req_misaligned  = (req_addr[1:0] != 2'b00);
    // Byte offset of a load is meaningless for a word store.
    assign unused_load_lsb = ^load_addr[1:0];

    // A load owns the array for the cycle, so a fetch never collides with it.
    assign req_ready = rst_n & ~stall & ~flush & ~load_en;
    assign accept    = req_valid & req_ready;

    // Program load; contents survive reset and loads are ignored in reset.
    always_ff @(posedge clk) begin
        if (rst_n && load_en) begin
            mem[load_idx] <= load_data;
        end
    end

    // Response register: reset > flush > stall hold > accept > bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid      <= 1'b0;
            rsp_data       <= NOP_WORD;
            rsp_addr       <= '0;
            rsp_misaligned <= 1'b0;
        end else if (flush) begin
            rsp_valid      <= 1'b0;
            rsp_data       <= NOP_WORD;
            rsp_misaligned <= 1'b0;
        end else if (stall) begin
            rsp_valid      <= rsp_valid;
            rsp_data       <= rsp_data;
            rsp_addr       <= rsp_addr;
            rsp_misaligned <= rsp_misaligned;
        end else if (accept) begin
            rsp_valid      <= 1'b1;
            rsp_addr       <= req_addr;
            rsp_misaligned <= req_misaligned;
            rsp_data       <= req_misaligned ? NOP_WORD : mem[req_idx];
        end else begin
            rsp_valid      <= 1'b0;
            rsp_data       <= NOP_WORD;
            rsp_misaligned <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Bench for instr_fetch_mem: directed scenarios plus a randomized run
// against a behavioural model of the fetch/load rules.
module tb_instr_fetch_mem;

    localparam int AW = 9;
    localparam int DW = 32;
    localparam int DEPTH = 2 ** (AW - 2);
    localparam logic [DW-1:0] NOP = 32'h00000013;
    localparam logic [DW-1:0] W0 = 32'h00100093;
    localparam logic [DW-1:0] W1 = 32'h00800093;
    localparam logic [DW-1:0] W2 = 32'h00208113;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic load_en = 1'b0;
    logic [AW-1:0] load_addr = '0;
    logic [DW-1:0] load_data = '0;
    logic req_valid = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic stall = 1'b0;
    logic flush = 1'b0;
    logic req_ready;
    logic rsp_valid;
    logic [DW-1:0] rsp_data;
    logic [AW-1:0] rsp_addr;
    logic rsp_misaligned;

    int n_checks = 0;
    int n_fail = 0;

    logic [DW-1:0] ref_mem [DEPTH];
    logic e_valid = 1'b0;
    logic [DW-1:0] e_data = NOP;
    logic [AW-1:0] e_addr = '0;
    logic e_mis = 1'b0;
    bit addr_known = 1'b0;
    bit mis_known = 1'b0;

    always #5 clk = ~clk;

    instr_fetch_mem dut (
        .clk(clk),
        .rst_n(rst_n),
        .load_en(load_en),
        .load_addr(load_addr),
        .load_data(load_data),
        .req_valid(req_valid),
        .req_addr(req_addr),
        .req_ready(req_ready),
        .stall(stall),
        .flush(flush),
        .rsp_valid(rsp_valid),
        .rsp_data(rsp_data),
        .rsp_addr(rsp_addr),
        .rsp_misaligned(rsp_misaligned)
    );

    function automatic logic exp_ready();
        return rst_n && !stall && !flush && !load_en;
    endfunction

    // Advance the model by the rules for the current inputs, then clock.
    task automatic cycle();
        logic acc;
        acc = req_valid && exp_ready();
        if (!rst_n) begin
            e_valid = 1'b0; e_data = NOP; e_addr = '0; e_mis = 1'b0;
            addr_known = 1'b1; mis_known = 1'b1;
        end else begin
            if (flush) begin
                e_valid = 1'b0; e_data = NOP; e_mis = 1'b0;
                mis_known = 1'b1; addr_known = 1'b0;
            end else if (stall) begin
                e_valid = e_valid;
            end else if (acc) begin
                e_valid = 1'b1;
                e_addr = req_addr;
                e_mis = (req_addr % 4) != 0;
                e_data = e_mis ? NOP : ref_mem[req_addr / 4];
                addr_known = 1'b1; mis_known = 1'b1;
            end else begin
                e_valid = 1'b0; e_data = NOP;
                addr_known = 1'b0; mis_known = 1'b0;
            end
            if (load_en) ref_mem[load_addr / 4] = load_data;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        load_en = 1'b0; req_valid = 1'b0;
        stall = 1'b0; flush = 1'b0; rst_n = 1'b1;
    endtask

    task automatic fetch(input logic [AW-1:0] a);
        idle();
        req_valid = 1'b1; req_addr = a;
        cycle();
        req_valid = 1'b0;
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
        idle();
        load_en = 1'b1; load_addr = a; load_data = d;
        cycle();
        load_en = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b1; req_addr = 9'h010;
        load_en = 1'b1; load_addr = 9'h010; load_data = 32'hdeadbeef;
        #1;
        n_checks++;
        if (req_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_ready: got %b want 0", req_ready);
        end
        cycle();
        cycle();
        n_checks++;
        if (rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %b want 0", rsp_valid);
        end
        n_checks++;
        if (rsp_data !== NOP) begin
            n_fail++; $display("FAIL reset_data: got %h want %h", rsp_data, NOP);
        end
        n_checks++;
        if (rsp_addr !== '0 || rsp_misaligned !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_addr_mis: got %h/%b want 000/0", rsp_addr, rsp_misaligned);
        end
        fetch(9'h010);
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== NOP) begin
            n_fail++;
            $display("FAIL init_nop: got %b/%h want 1/%h", rsp_valid, rsp_data, NOP);
        end
    endtask

    task automatic test_load_fetch();
        load(9'h000, W0);
        load(9'h004, W1);
        load(9'h008, W2);
        fetch(9'h004);
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== W1 || rsp_addr !== 9'h004) begin
            n_fail++;
            $display("FAIL load_fetch: got %b/%h/%h want 1/%h/004", rsp_valid, rsp_data, rsp_addr, W1);
        end
        idle();
        cycle();
        n_checks++;
        if (rsp_valid !== 1'b0 || rsp_data !== NOP) begin
            n_fail++; $display("FAIL bubble: got %b/%h want 0/%h", rsp_valid, rsp_data, NOP);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] w [3];
        w[0] = W0; w[1] = W1; w[2] = W2;
        idle();
        req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_addr = AW'(4 * i);
            #1;
            n_checks++;
            if (req_ready !== 1'b1) begin
                n_fail++; $display("FAIL stream_ready[%0d]: got %b want 1", i, req_ready);
            end
            cycle();
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== w[i] || rsp_addr !== AW'(4 * i)) begin
                n_fail++;
                $display("FAIL stream[%0d]: got %b/%h/%h want 1/%h/%h", i, rsp_valid, rsp_data, rsp_addr, w[i], 4 * i);
            end
        end
        req_valid = 1'b0;
    endtask

    task automatic test_stall();
        fetch(9'h004);
        stall = 1'b1; req_valid = 1'b1; req_addr = 9'h008;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (req_ready !== 1'b0) begin
                n_fail++; $display("FAIL stall_ready[%0d]: got %b want 0", i, req_ready);
            end
            cycle();
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== W1 || rsp_addr !== 9'h004 || rsp_misaligned !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got %b/%h/%h/%b want 1/%h/004/0", i, rsp_valid, rsp_data, rsp_addr, rsp_misaligned, W1);
            end
        end
        stall = 1'b0;
        cycle();
        req_valid = 1'b0;
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== W2 || rsp_addr !== 9'h008) begin
            n_fail++;
            $display("FAIL stall_resume: got %b/%h/%h want 1/%h/008", rsp_valid, rsp_data, rsp_addr, W2);
        end
    endtask

    task automatic test_flush();
        fetch(9'h000);
        stall = 1'b1; flush = 1'b1; req_valid = 1'b1; req_addr = 9'h008;
        load_en = 1'b1; load_addr = 9'h00c; load_data = 32'h00c00193;
        #1;
        n_checks++;
        if (req_ready !== 1'b0) begin
            n_fail++; $display("FAIL flush_ready: got %b want 0", req_ready);
        end
        cycle();
        n_checks++;
        if (rsp_valid !== 1'b0 || rsp_data !== NOP || rsp_misaligned !== 1'b0) begin
            n_fail++;
            $display("FAIL flush: got %b/%h/%b want 0/%h/0", rsp_valid, rsp_data, rsp_misaligned, NOP);
        end
        idle();
        cycle();
        n_checks++;
        if (rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_drop: got %b want 0", rsp_valid);
        end
        fetch(9'h00c);
        n_checks++;
        if (rsp_data !== 32'h00c00193) begin
            n_fail++; $display("FAIL flush_load: got %h want 00c00193", rsp_data);
        end
    endtask

    task automatic test_misaligned();
        fetch(9'h006);
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_misaligned !== 1'b1 || rsp_data !== NOP || rsp_addr !== 9'h006) begin
            n_fail++;
            $display("FAIL misaligned: got %b/%b/%h/%h want 1/1/%h/006", rsp_valid, rsp_misaligned, rsp_data, rsp_addr, NOP);
        end
    endtask

    task automatic test_wrap();
        load(9'h1fc, 32'h7ff00f93);
        fetch(9'h1fc);
        n_checks++;
        if (rsp_data !== 32'h7ff00f93 || rsp_addr !== 9'h1fc) begin
            n_fail++; $display("FAIL wrap: got %h/%h want 7ff00f93/1fc", rsp_data, rsp_addr);
        end
    endtask

    task automatic test_reset_in_stall();
        fetch(9'h004);
        stall = 1'b1;
        cycle();
        rst_n = 1'b0;
        cycle();
        n_checks++;
        if (rsp_valid !== 1'b0 || rsp_addr !== '0 || rsp_data !== NOP) begin
            n_fail++;
            $display("FAIL reset_stall: got %b/%h/%h want 0/000/%h", rsp_valid, rsp_addr, rsp_data, NOP);
        end
        fetch(9'h004);
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== W1) begin
            n_fail++; $display("FAIL reset_keep_mem: got %b/%h want 1/%h", rsp_valid, rsp_data, W1);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 500; i++) begin
            rst_n = ($urandom_range(0, 39) != 0);
            load_en = ($urandom_range(0, 4) == 0);
            stall = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 9) == 0);
            req_valid = ($urandom_range(0, 9) < 7);
            req_addr = AW'($urandom_range(0, DEPTH - 1) * 4);
            if ($urandom_range(0, 5) == 0) req_addr[1:0] = 2'($urandom_range(1, 3));
            load_addr = AW'($urandom);
            load_data = $urandom;
            #1;
            n_checks++;
            if (req_ready !== exp_ready()) begin
                n_fail++; $display("FAIL rnd_ready[%0d]: got %b want %b", i, req_ready, exp_ready());
            end
            cycle();
            n_checks++;
            if (rsp_valid !== e_valid || rsp_data !== e_data) begin
                n_fail++;
                $display("FAIL rnd_rsp[%0d]: got %b/%h want %b/%h", i, rsp_valid, rsp_data, e_valid, e_data);
            end
            if (addr_known) begin
                n_checks++;
                if (rsp_addr !== e_addr) begin
                    n_fail++; $display("FAIL rnd_addr[%0d]: got %h want %h", i, rsp_addr, e_addr);
                end
            end
            if (mis_known) begin
                n_checks++;
                if (rsp_misaligned !== e_mis) begin
                    n_fail++; $display("FAIL rnd_mis[%0d]: got %b want %b", i, rsp_misaligned, e_mis);
                end
            end
        end
        idle();
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = NOP;
        #1;
        test_reset();
        test_load_fetch();
        test_back_to_back();
        test_stall();
        test_flush();
        test_misaligned();
        test_wrap();
        test_reset_in_stall();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
